// File: rtl/mod_counter_if.sv
// Purpose: control/status bundle for mod_counter (count enable, direction, load, ovf clear; value and flags back).
// Latency: pure wiring, no storage.
// Backpressure: none; the counter side accepts every strobe on every clock.
// Signals:
//   t, up, load, d, clr_ovf : driven by the master (counter user)
//   o, tc, ovf              : driven by the slave (counter)
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             t;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             clr_ovf;
  logic [WIDTH-1:0] o;
  logic             tc;
  logic             ovf;

  modport master (
    output t, up, load, d, clr_ovf,
    input  o, tc, ovf
  );

  modport slave (
    input  t, up, load, d, clr_ovf,
    output o, tc, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// Purpose: prescaled up/down modulo counter with clamped load, wrap/saturate, tc pulse and sticky ovf.
// Latency: one clock; load or tick sampled on an edge is visible on o right after that edge.
// Backpressure: none; every enabled cycle is consumed, t=0 simply freezes the prescaler.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset (o, tc, ovf, prescaler -> 0)
//   bus     : mod_counter_if.slave (t, up, load, d, clr_ovf in; o, tc, ovf out)
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clock,
  input  logic         reset,
  mod_counter_if.slave bus
);

  localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] o_q, o_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    pre_q, pre_d;

  logic             pre_last;
  logic             tick;
  logic             bnd;

  // With PRESCALE=1 pre stays 0 and PLAST is 0, so every t=1 cycle ticks.
  assign pre_last = (pre_q == PLAST);
  assign tick     = bus.t && pre_last;

  always_comb begin
    o_d   = o_q;
    pre_d = pre_q;
    bnd   = 1'b0;

    if (bus.load) begin
      // Out-of-range load values clamp to the top of the range; any tick this cycle is dropped.
      o_d   = (bus.d > MAXV) ? MAXV : bus.d;
      pre_d = '0;
    end else begin
      if (bus.t) begin
        pre_d = pre_last ? '0 : pre_q + PW'(1);
      end
      if (tick) begin
        if (bus.up) begin
          if (o_q == MAXV) begin
            bnd = 1'b1;
            o_d = (SATURATE != 0) ? o_q : '0;
          end else begin
            o_d = o_q + WIDTH'(1);
          end
        end else begin
          if (o_q == '0) begin
            bnd = 1'b1;
            o_d = (SATURATE != 0) ? o_q : MAXV;
          end else begin
            o_d = o_q - WIDTH'(1);
          end
        end
      end
    end

    tc_d = bnd;
    // A boundary event on the same edge beats the clear.
    ovf_d = bus.clr_ovf ? 1'b0 : ovf_q;
    if (bnd) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      pre_q <= '0;
    end else begin
      o_q   <= o_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      pre_q <= pre_d;
    end
  end

  assign bus.o   = o_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous up/down counter; next-generation replacement for the fixed 8-bit toggle-driven ripple counter. Adds configurable width, modulus, prescaled count enable, direction control, parallel load, wrap/saturate mode, a terminal-count pulse and a sticky overflow flag. All state changes on one clock edge, with no ripple-clocked stages. Sits anywhere the design needs a divider, event counter or timebase.

## Interface
- WIDTH, 8: counter width in bits.
- MODULUS, 256: count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- PRESCALE, 1: number of enabled cycles per count step; >= 1.
- SATURATE, 0: 0 = wrap at boundary, 1 = hold at boundary.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- t  in  1  count enable; prescaler advances on each cycle t=1.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on tick cycles.
- load  in  1  parallel load strobe.
- d  in  WIDTH  load value.
- clr_ovf  in  1  clears sticky overflow flag.
- o  out  WIDTH  counter value, registered.
- tc  out  1  terminal-count pulse, one cycle, registered.
- ovf  out  1  sticky boundary flag, registered.

## Operation
- Priority per edge: reset > load > count step.
- Reset: o=0, tc=0, ovf=0, prescaler=0.
- Prescaler pre, width clog2(PRESCALE) (min 1):
  - A tick occurs on a cycle with t=1 and pre==PRESCALE-1; pre then returns to 0.
  - Otherwise t=1 increments pre; t=0 holds pre.
  - PRESCALE=1: tick = t.
- Load (load=1): o = d if d < MODULUS, else o = MODULUS-1 (clamp).
  - pre cleared; tc=0 that edge.
  - A tick in the same cycle is discarded.
  - ovf unchanged.
- Tick, up=1:
  - o < MODULUS-1: o+1.
  - o == MODULUS-1: o=0 (SATURATE=0) or hold (SATURATE=1); boundary event.
- Tick, up=0:
  - o > 0: o-1.
  - o == 0: o=MODULUS-1 (SATURATE=0) or hold (SATURATE=1); boundary event.
- Boundary event: tc=1 on the same edge, ovf=1. In SATURATE mode every tick that attempts to pass the boundary is an event, so tc pulses on each such tick.
- tc=0 on every edge without a boundary event.
- clr_ovf=1 clears ovf unless a boundary event occurs on the same edge; set wins.
- Arithmetic is modulo MODULUS, not 2^WIDTH. The counter never holds a value >= MODULUS.

## Timing
- Latency: o reflects a tick or load on the edge that samples it, so it is visible the following cycle.
- tc is high exactly one cycle per boundary event, aligned with the edge that wraps or holds o.
- t=1 continuous with PRESCALE=P gives one step every P cycles. The first step occurs P cycles after t rises from a cleared prescaler.
- Dropping t mid-prescale freezes pre. No step is lost or duplicated on resume.
- Reset asserted mid-count takes effect on the next edge regardless of t/load. Outputs are 0 from the following cycle.
- Direction change on a tick cycle applies to that tick only. No turnaround penalty.

## Test plan
- Reset, then WIDTH=8, MODULUS=256, PRESCALE=1, t=1, up=1 for 300 cycles -> o runs 0..255, wraps to 0 at cycle 256, tc high for that single cycle, ovf=1.
- MODULUS=10, up=0 from reset -> o goes 0 -> 9 -> 8 on the first two ticks, tc pulses on the first tick; clr_ovf=1 -> ovf=0 next cycle.
- MODULUS=10, SATURATE=1, up=1, 12 ticks -> o holds at 9 after tick 9, tc pulses on ticks 10, 11 and 12, o never reaches 0.
- PRESCALE=4, t=1 for 16 cycles with t=0 for 3 cycles inserted after cycle 6 -> o advances exactly 4 times, steps spaced 4 enabled cycles apart.
- MODULUS=10, load=1, d=15 with t=1 in the same cycle -> o=9, no step, tc=0. Next tick, up=1 -> o=0, tc=1.
- Count to o=37, assert reset for one cycle while load=1 and t=1 -> o=0, tc=0, ovf=0. Counting resumes from 0, and the first step comes PRESCALE enabled cycles later.
